alu_issue_stage: RTL and testbench

//  Decode/issue stage that feeds v_alu. It accepts a decoded-slot packet {instr, pc, rs1_data, rs2_data}
//  via valid/ready and produces a registered ALU command {alu_a, alu_b, alu_op, rd, rd_we}.
//  It has a 2-entry skid buffer, so in_ready is a registered signal with no combinational path from out_ready.

---
 rtl/alu_issue_stage_pkg.sv | 55 +++++
 rtl/alu_cmd_decode.sv | 78 +++++++
 rtl/alu_issue_stage.sv | 126 ++++++++++++
 tb/tb_alu_issue_stage.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_stage_pkg.sv
// rtl/alu_issue_stage_pkg.sv - ALU op codes, RV32I opcode/funct7 constants and the ALU command type
package alu_issue_stage_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
  } alu_cmd_t;

  // Occupancy encoded as {skid_valid, out_valid}
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b11
  } skid_state_e;

  // alt selects SUB for f3=000 and SRA for f3=101
  function automatic logic [3:0] f3_to_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_cmd_decode.sv
// rtl/alu_cmd_decode.sv - combinational RV32I OP/OP-IMM/LUI/AUIPC decode into an ALU command
module alu_cmd_decode
  import alu_issue_stage_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output alu_cmd_t    cmd
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic [3:0]  dec_op;
  logic        dec_legal;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_u  = {instr[31:12], 12'b0};

  always_comb begin
    dec_a     = '0;
    dec_b     = '0;
    dec_op    = ALU_ADD;
    dec_legal = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_a     = rs1_data;
        dec_b     = rs2_data;
        dec_op    = f3_to_op(f3, f7 == F7_ALT);
        dec_legal = (f7 == F7_BASE) ||
                    ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
      end
      OPC_OPIMM: begin
        dec_a     = rs1_data;
        dec_b     = imm_i;
        dec_op    = f3_to_op(f3, 1'b0);
        dec_legal = 1'b1;
        // Shift-immediates reuse the top imm bits as funct7
        if (f3 == 3'b001) begin
          dec_b     = {27'b0, instr[24:20]};
          dec_legal = (f7 == F7_BASE);
        end else if (f3 == 3'b101) begin
          dec_b     = {27'b0, instr[24:20]};
          dec_op    = f3_to_op(f3, f7 == F7_ALT);
          dec_legal = (f7 == F7_BASE) || (f7 == F7_ALT);
        end
      end
      OPC_LUI: begin
        dec_b     = imm_u;
        dec_legal = 1'b1;
      end
      OPC_AUIPC: begin
        dec_a     = pc;
        dec_b     = imm_u;
        dec_legal = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    cmd.rd      = instr[11:7];
    cmd.illegal = !dec_legal;
    cmd.a       = dec_legal ? dec_a : '0;
    cmd.b       = dec_legal ? dec_b : '0;
    cmd.op      = dec_legal ? dec_op : ALU_ADD;
    cmd.rd_we   = dec_legal && (instr[11:7] != 5'd0);
  end

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - issue stage: decode into a 2-entry skid buffer feeding the ALU
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit RESET_PC_OK = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  output logic [4:0]      rd,
  output logic            rd_we,
  output logic            illegal
);

  alu_cmd_t    dec_cmd;
  alu_cmd_t    main_q, main_d;
  alu_cmd_t    skid_q, skid_d;
  logic        out_valid_q, out_valid_d;
  logic        skid_valid_q, skid_valid_d;
  logic        accept;
  logic        emit;
  skid_state_e state;

  alu_cmd_decode u_decode (
    .instr    (instr),
    .pc       (pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .cmd      (dec_cmd)
  );

  // Status bits always clear; payload clears only when RESET_PC_OK is set
  function automatic alu_cmd_t reset_cmd(input alu_cmd_t c);
    alu_cmd_t r;
    r         = c;
    r.rd_we   = 1'b0;
    r.illegal = 1'b0;
    if (RESET_PC_OK) begin
      r.a  = '0;
      r.b  = '0;
      r.op = ALU_ADD;
      r.rd = '0;
    end
    return r;
  endfunction

  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && !skid_valid_q;
  assign emit     = out_valid_q && out_ready;
  assign state    = skid_state_e'({skid_valid_q, out_valid_q});

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            main_d      = dec_cmd;
            out_valid_d = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && emit) begin
            main_d = dec_cmd;
          end else if (accept) begin
            skid_d       = dec_cmd;
            skid_valid_d = 1'b1;
          end else if (emit) begin
            out_valid_d = 1'b0;
          end
        end
        ST_TWO: begin
          if (emit) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
          end
        end
        default: begin
          out_valid_d  = 1'b0;
          skid_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= reset_cmd(main_q);
      skid_q       <= reset_cmd(skid_q);
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_a     = main_q.a;
  assign alu_b     = main_q.b;
  assign alu_op    = main_q.op;
  assign rd        = main_q.rd;
  assign rd_we     = main_q.rd_we;
  assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - scoreboard bench for alu_issue_stage
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
  } exp_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    exp_t        e;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [4:0]  rd;
  logic        rd_we;
  logic        illegal;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_emit = 0;
  exp_t sb[$];
  exp_t drv_exp;
  exp_t got;
  exp_t prev_out;
  logic stall_prev;

  alu_issue_stage #(.XLEN(32), .RESET_PC_OK(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .pc        (pc),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .rd        (rd),
    .rd_we     (rd_we),
    .illegal   (illegal)
  );

  assign got = {alu_a, alu_b, alu_op, rd, rd_we, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Scoreboard monitor: pushes on accept, pops and compares on emit, checks hold while stalled
  initial begin
    exp_t e;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (stall_prev) begin
        n_cmp++;
        if (out_valid !== 1'b1 || got !== prev_out) begin
          n_bad++;
          $display("FAIL hold_stable: got valid=%b cmd=%h required valid=1 cmd=%h", out_valid, got, prev_out);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1 && rst !== 1'b1) begin
        n_emit++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL sb_unexpected: got cmd=%h required no output", got);
        end else begin
          e = sb.pop_front();
          if (got !== e) begin
            n_bad++;
            $display("FAIL sb_order: got cmd=%h required cmd=%h", got, e);
          end
        end
      end
      if (rst === 1'b1 || flush === 1'b1) sb.delete();
      else if (in_valid === 1'b1 && in_ready === 1'b1) sb.push_back(drv_exp);
      stall_prev = (out_valid === 1'b1) && (out_ready === 1'b0) && (rst === 1'b0) && (flush === 1'b0);
      prev_out = got;
    end
  end

  function automatic vec_t mk_addi(input int k);
    vec_t v;
    logic [11:0] imm;
    logic [4:0]  rdx;
    imm   = 12'h010 + 12'(k);
    rdx   = 5'(k + 1);
    v.instr = {imm, 5'd1, 3'b000, rdx, 7'b0010011};
    v.pc    = 32'h2000 + 32'(k * 4);
    v.rs1   = 32'h100 * 32'(k + 1);
    v.rs2   = 32'hA5A5_0000;
    v.e     = '{a: v.rs1, b: {20'd0, imm}, op: ALU_ADD, rd: rdx, rd_we: 1'b1, illegal: 1'b0};
    return v;
  endfunction

  task automatic drive(input vec_t v);
    instr    = v.instr;
    pc       = v.pc;
    rs1_data = v.rs1;
    rs2_data = v.rs2;
    drv_exp  = v.e;
    in_valid = 1'b1;
  endtask

  // Holds the packet until accepted; returns 1ns after the accepting edge
  task automatic send(input vec_t v);
    int   waited;
    logic acc;
    drive(v);
    waited = 0;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc === 1'b1) break;
      waited++;
      if (waited > 20) begin
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout: got in_ready=%b required 1 within 20 cycles", in_ready);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    exp_t rst_e;
    rst_e = '{a: 32'd0, b: 32'd0, op: ALU_ADD, rd: 5'd0, rd_we: 1'b0, illegal: 1'b0};
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_out_valid: got %b required 0", out_valid);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    n_cmp++;
    if (got !== rst_e) begin
      n_bad++;
      $display("FAIL reset_cmd: got %h required %h", got, rst_e);
    end
  endtask

  task automatic test_decode();
    vec_t v[14];
    v[0]  = '{32'h40208133, 32'h100, 32'd5, 32'd7,
              '{32'd5, 32'd7, ALU_SUB, 5'd2, 1'b1, 1'b0}};
    v[1]  = '{32'hFFF00293, 32'h104, 32'd0, 32'd99,
              '{32'd0, 32'hFFFFFFFF, ALU_ADD, 5'd5, 1'b1, 1'b0}};
    v[2]  = '{32'h123450B7, 32'h108, 32'hDEAD, 32'hBEEF,
              '{32'd0, 32'h12345000, ALU_ADD, 5'd1, 1'b1, 1'b0}};
    v[3]  = '{32'h40725193, 32'h10C, 32'h80000000, 32'h55,
              '{32'h80000000, 32'd7, ALU_SRA, 5'd3, 1'b1, 1'b0}};
    v[4]  = '{32'h02725193, 32'h110, 32'h80000000, 32'h55,
              '{32'd0, 32'd0, ALU_ADD, 5'd3, 1'b0, 1'b1}};
    v[5]  = '{32'h0000006F, 32'h114, 32'h1234, 32'h5678,
              '{32'd0, 32'd0, ALU_ADD, 5'd0, 1'b0, 1'b1}};
    v[6]  = '{32'h00208033, 32'h118, 32'h11, 32'h22,
              '{32'h11, 32'h22, ALU_ADD, 5'd0, 1'b0, 1'b0}};
    v[7]  = '{32'hFFFFF397, 32'h1000, 32'h77, 32'h88,
              '{32'h1000, 32'hFFFFF000, ALU_ADD, 5'd7, 1'b1, 1'b0}};
    v[8]  = '{32'h0020B333, 32'h120, 32'h3, 32'hFFFFFFFE,
              '{32'h3, 32'hFFFFFFFE, ALU_SLTU, 5'd6, 1'b1, 1'b0}};
    v[9]  = '{32'h4020C133, 32'h124, 32'h9, 32'hA,
              '{32'd0, 32'd0, ALU_ADD, 5'd2, 1'b0, 1'b1}};
    v[10] = '{32'h7F04F413, 32'h128, 32'hFFFF00FF, 32'h1,
              '{32'hFFFF00FF, 32'h7F0, ALU_AND, 5'd8, 1'b1, 1'b0}};
    v[11] = '{32'h01F59513, 32'h12C, 32'h1, 32'h2,
              '{32'h1, 32'd31, ALU_SLL, 5'd10, 1'b1, 1'b0}};
    v[12] = '{32'h4062D233, 32'h130, 32'hF0000000, 32'h4,
              '{32'hF0000000, 32'h4, ALU_SRA, 5'd4, 1'b1, 1'b0}};
    v[13] = '{32'h80022193, 32'h134, 32'h42, 32'h43,
              '{32'h42, 32'hFFFFF800, ALU_SLT, 5'd3, 1'b1, 1'b0}};
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      send(v[i]);
      n_cmp++;
      if (out_valid !== 1'b1 || got !== v[i].e) begin
        n_bad++;
        $display("FAIL decode_%0d: got valid=%b cmd=%h required valid=1 cmd=%h", i, out_valid, got, v[i].e);
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back_backpressure();
    int   base;
    vec_t p0;
    p0   = mk_addi(0);
    base = n_emit;
    out_ready = 1'b0;
    send(p0);
    send(mk_addi(1));
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_in_ready_low: got %b required 0", in_ready);
    end
    drive(mk_addi(2));
    @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || got !== p0.e) begin
      n_bad++;
      $display("FAIL bp_stall_head: got rdy=%b valid=%b cmd=%h required rdy=0 valid=1 cmd=%h",
               in_ready, out_valid, got, p0.e);
    end
    out_ready = 1'b1;
    send(mk_addi(2));
    send(mk_addi(3));
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (n_emit - base !== 4) begin
      n_bad++;
      $display("FAIL bp_emit_count: got %0d required 4", n_emit - base);
    end
    n_cmp++;
    if (sb.size() !== 0) begin
      n_bad++;
      $display("FAIL bp_drained: got %0d pending required 0", sb.size());
    end
  endtask

  task automatic test_flush();
    int base;
    base = n_emit;
    out_ready = 1'b0;
    send(mk_addi(4));
    send(mk_addi(5));
    drive(mk_addi(6));
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_empty: got valid=%b rdy=%b required valid=0 rdy=1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (n_emit !== base) begin
      n_bad++;
      $display("FAIL flush_no_emit: got %0d emits required 0", n_emit - base);
    end
    send(mk_addi(7));
    @(posedge clk);
    #1;
    n_cmp++;
    if (n_emit !== base + 1 || sb.size() !== 0) begin
      n_bad++;
      $display("FAIL flush_recover: got %0d emits %0d pending required 1 emits 0 pending",
               n_emit - base, sb.size());
    end
  endtask

  task automatic test_mid_reset();
    vec_t jal_v;
    exp_t rst_e;
    jal_v = '{32'h0000006F, 32'h300, 32'h1, 32'h2, '{32'd0, 32'd0, ALU_ADD, 5'd0, 1'b0, 1'b1}};
    rst_e = '{a: 32'd0, b: 32'd0, op: ALU_ADD, rd: 5'd0, rd_we: 1'b0, illegal: 1'b0};
    out_ready = 1'b0;
    send(jal_v);
    send(mk_addi(8));
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_valid: got valid=%b rdy=%b required valid=0 rdy=1", out_valid, in_ready);
    end
    n_cmp++;
    if (got !== rst_e) begin
      n_bad++;
      $display("FAIL midrst_cmd: got %h required %h", got, rst_e);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    send(mk_addi(9));
    @(posedge clk);
    #1;
    n_cmp++;
    if (sb.size() !== 0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_recover: got %0d pending valid=%b required 0 pending valid=0", sb.size(), out_valid);
    end
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    instr     = '0;
    pc        = '0;
    rs1_data  = '0;
    rs2_data  = '0;
    drv_exp   = '0;
    test_reset();
    test_decode();
    test_back_to_back_backpressure();
    test_flush();
    test_mid_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (sb.size() !== 0) begin
      n_bad++;
      $display("FAIL final_drain: got %0d pending required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
